stream_demux_1xn: RTL

- Registered 1-to-N stream demultiplexer with valid/ready handshake on the input and on every output channel. Successor to the combinational 1x8 demux.
- Adds a parametrised channel count and data width, a one-entry output register per channel, packet-lock routing and invalid-select dropping with an error counter.
- Sits between a single producer and N consumer engines in the datapath.

---
 rtl/stream_demux_pkg.sv | 5 +
 rtl/demux_out_reg.sv | 38 +++
 rtl/stream_demux_1xn.sv | 87 ++++++++
 3 files changed

// File: rtl/stream_demux_pkg.sv
// stream_demux_pkg: shared FSM encoding and drop counter width for the stream demux
package stream_demux_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DROP = 2'd2} state_e;
  localparam int DROP_CW = 8;
endpackage

// File: rtl/demux_out_reg.sv
// demux_out_reg: one-entry valid/ready output register holding data plus last
module demux_out_reg #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [DW-1:0] data_i,
  input  logic          last_i,
  input  logic          ready_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o,
  output logic          last_o,
  output logic          space_o
);
  logic          valid_q, valid_d, last_q, last_d;
  logic [DW-1:0] data_q, data_d;
  always_comb begin
    valid_d = load_i | (valid_q & ~ready_i);
    data_d  = load_i ? data_i : data_q;
    last_d  = load_i ? last_i : last_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end
  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;
  assign space_o = ~valid_q | ready_i;
endmodule

// File: rtl/stream_demux_1xn.sv
// stream_demux_1xn: registered 1-to-N valid/ready demux with packet lock and invalid-select dropping
module stream_demux_1xn
  import stream_demux_pkg::*;
#(
  parameter int N_CH     = 8,
  parameter int DW       = 8,
  parameter int PKT_MODE = 1,
  localparam int SW      = $clog2(N_CH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DW-1:0]        in_data,
  input  logic [SW-1:0]        in_sel,
  input  logic                 in_last,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [N_CH*DW-1:0]   out_data,
  output logic [N_CH-1:0]      out_last,
  output logic [N_CH-1:0]      out_valid,
  input  logic [N_CH-1:0]      out_ready,
  output logic                 err_sel,
  output logic [DROP_CW-1:0]   drop_cnt
);
  state_e               state_q, state_d;
  logic [SW-1:0]        lock_q, lock_d, tgt;
  logic                 err_q, err_d, tgt_ok, sink, acc, drop;
  logic [DROP_CW-1:0]   cnt_q, cnt_d;
  logic [N_CH-1:0]      space, load;
  logic [2**SW-1:0]     space_ext;
  always_comb begin
    space_ext = '0;
    space_ext[N_CH-1:0] = space;
  end
  assign tgt      = (state_q == BUSY) ? lock_q : in_sel;
  assign tgt_ok   = int'(tgt) < N_CH;
  assign sink     = ~tgt_ok | (state_q == DROP);
  assign in_ready = sink | space_ext[tgt];
  assign acc      = in_valid & in_ready;
  assign drop     = acc & sink;
  // only the first sunk beat of a packet is seen outside DROP, so it alone raises err_sel
  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    if (PKT_MODE != 0 && acc) begin
      if (state_q == IDLE) begin
        if (!in_last) begin
          state_d = tgt_ok ? BUSY : DROP;
          lock_d  = tgt_ok ? in_sel : lock_q;
        end
      end else if (in_last) begin
        state_d = IDLE;
      end
    end
    err_d = drop & (state_q != DROP);
    cnt_d = (drop && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lock_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end
  assign err_sel  = err_q;
  assign drop_cnt = cnt_q;
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    assign load[c] = acc & ~sink & (tgt == SW'(c));
    demux_out_reg #(.DW(DW)) u_reg (
      .clk     (clk),
      .rst     (rst),
      .load_i  (load[c]),
      .data_i  (in_data),
      .last_i  (in_last),
      .ready_i (out_ready[c]),
      .valid_o (out_valid[c]),
      .data_o  (out_data[c*DW +: DW]),
      .last_o  (out_last[c]),
      .space_o (space[c])
    );
  end
endmodule
